// File: rtl/gaussian_conv3x3.sv
// ============================================================================
// Module   : gaussian_conv3x3
// Brief    : Streaming 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16) over one
//            raster-order greyscale frame using two internal line buffers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gaussian_conv3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_pix,
    output logic       out_valid,
    output logic [7:0] out_pix,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic          flush_cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    logic          w_accept;
    logic          w_at_end;
    logic          w_win_done;

    assign w_accept   = in_valid && (state_q == S_RUN);
    assign w_at_end   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign w_win_done = w_accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    // Control FSM and raster counters; counters only move on accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_at_end) begin
                            state_q     <= S_FLUSH;
                            flush_cnt_q <= 1'b0;
                            col_q       <= '0;
                            row_q       <= '0;
                        end else if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        flush_cnt_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2 at each column.
    logic [7:0] lb0_q [IMG_W];
    logic [7:0] lb1_q [IMG_W];
    logic [7:0] w_b0;
    logic [7:0] w_b1;

    assign w_b0 = lb0_q[col_q];
    assign w_b1 = lb1_q[col_q];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            lb0_q[col_q] <= in_pix;
            lb1_q[col_q] <= lb0_q[col_q];
        end
    end

    // Two previous window columns; the third column is the incoming beat.
    logic [7:0] win_q [3][2];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
            end
            win_q[0][1] <= w_b1;
            win_q[1][1] <= w_b0;
            win_q[2][1] <= in_pix;
        end
    end

    logic [11:0] sum_d;
    logic [11:0] sum_q;
    logic        valid1_q;
    logic        last1_q;

    always_comb begin
        sum_d = {4'd0, win_q[0][0]} + {4'd0, w_b1} + {4'd0, win_q[2][0]} + {4'd0, in_pix}
              + (({4'd0, win_q[0][1]} + {4'd0, win_q[1][0]} + {4'd0, w_b0} + {4'd0, win_q[2][1]}) << 1)
              + ({4'd0, win_q[1][1]} << 2);
    end

    always_ff @(posedge clk) begin
        if (w_win_done) begin
            sum_q <= sum_d;
        end
    end

    logic       out_valid_q;
    logic       out_last_q;
    logic [7:0] out_pix_q;
    logic [7:0] out_pix_d;

    // Max sum 4080 + 8 still fits 12 bits, so rounding saturates at 255 by itself.
    assign out_pix_d = 8'((sum_q + 12'd8) >> 4);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q    <= 1'b0;
            last1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pix_q   <= 8'd0;
        end else begin
            valid1_q    <= w_win_done;
            last1_q     <= w_win_done && w_at_end;
            out_valid_q <= valid1_q;
            out_last_q  <= valid1_q && last1_q;
            if (valid1_q) begin
                out_pix_q <= out_pix_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_gaussian_conv3x3.sv
// ============================================================================
// Module   : tb_gaussian_conv3x3
// Brief    : Self-checking bench for gaussian_conv3x3 on an 8x6 frame.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gaussian_conv3x3;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_pix;
    logic       out_valid;
    logic [7:0] out_pix;
    logic       out_last;
    logic       busy;
    logic       done;

    gaussian_conv3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_pix   (in_pix),
        .out_valid(out_valid),
        .out_pix  (out_pix),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int img [H][W];
    int beat_cyc [H*W];
    int q_pix[$];
    int q_last[$];
    int q_cyc[$];
    int d_cyc[$];
    int d_busy[$];

    typedef struct {
        int r;
        int c;
        int exp;
    } probe_t;

    probe_t probes [13];

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_pix.push_back(int'(out_pix));
            q_last.push_back(int'(out_last));
            q_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            d_cyc.push_back(cyc);
            d_busy.push_back(int'(busy));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: weighted 3x3 neighbourhood, rounded divide by 16.
    function automatic int model(input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += img[r+dr][c+dc] * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
        return (s + 8) / 16;
    endfunction

    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 100;
                    1: img[r][c] = (r == 2 && c == 3) ? 255 : 0;
                    2: img[r][c] = 10 * c;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    task automatic clear_capture();
        q_pix.delete();
        q_last.delete();
        q_cyc.delete();
        d_cyc.delete();
        d_busy.delete();
    endtask

    task automatic run_frame(input int gap_mode, input bit poke, input bit late_start);
        clear_capture();
        if (poke) begin
            repeat (3) begin
                @(posedge clk); #1;
                start = 1'b0; in_valid = 1'b1; in_pix = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; in_valid = poke; in_pix = 8'($urandom);
        for (int k = 0; k < H*W; k++) begin
            if (k > 0 && gap_mode != 0) begin
                int ng = (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
                for (int g = 0; g < ng; g++) begin
                    @(posedge clk); #1;
                    start = 1'b0; in_valid = 1'b0; in_pix = 8'($urandom);
                end
            end
            @(posedge clk); #1;
            start    = poke && (k == 17);
            in_valid = 1'b1;
            in_pix   = 8'(img[k / W][k % W]);
            beat_cyc[k] = cyc;
            if (k == 0) check("busy_run", int'(busy), 1);
        end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = late_start && (i == 3);
            if (i <= 2) check("busy_flush", int'(busy), 1);
            if (late_start && i >= 4 && i <= 6) check("late_start_ignored", int'(busy), 0);
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input bit ramp);
        int n;
        check("out_count", q_pix.size(), NOUT);
        n = (q_pix.size() < NOUT) ? q_pix.size() : NOUT;
        for (int i = 0; i < n; i++) begin
            int r = 1 + i / (W - 2);
            int c = 1 + i % (W - 2);
            check("pix", q_pix[i], model(r, c));
            if (ramp) check("ramp_pix", q_pix[i], 10 * c);
            check("last", q_last[i], (i == NOUT - 1) ? 1 : 0);
            check("latency", q_cyc[i] - beat_cyc[(r + 1) * W + c + 1], 2);
        end
        check("done_count", d_cyc.size(), 1);
        if (d_cyc.size() >= 1) begin
            check("done_after_last_beat", d_cyc[0] - beat_cyc[H*W - 1], 3);
            check("busy_at_done", d_busy[0], 0);
        end
    endtask

    task automatic check_probes();
        for (int p = 0; p < 13; p++) begin
            int idx = (probes[p].r - 1) * (W - 2) + (probes[p].c - 1);
            check("impulse_probe", (idx < q_pix.size()) ? q_pix[idx] : -1, probes[p].exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_pix"},   int'(out_pix),   0);
        check({tag, "_out_last"},  int'(out_last),  0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_done"},      int'(done),      0);
    endtask

    initial begin
        probes[0]  = '{2, 3, 64};
        probes[1]  = '{1, 3, 32};
        probes[2]  = '{3, 3, 32};
        probes[3]  = '{2, 2, 32};
        probes[4]  = '{2, 4, 32};
        probes[5]  = '{1, 2, 16};
        probes[6]  = '{1, 4, 16};
        probes[7]  = '{3, 2, 16};
        probes[8]  = '{3, 4, 16};
        probes[9]  = '{1, 1, 0};
        probes[10] = '{4, 6, 0};
        probes[11] = '{4, 3, 0};
        probes[12] = '{2, 6, 0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pix = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");

        fill(0); run_frame(0, 1'b0, 1'b1); check_frame(1'b0);
        fill(1); run_frame(0, 1'b0, 1'b0); check_frame(1'b0); check_probes();
        fill(2); run_frame(0, 1'b0, 1'b0); check_frame(1'b1);
        fill(0); run_frame(1, 1'b0, 1'b0); check_frame(1'b0);

        // Reset after 20 beats of a frame, then confirm the pipeline stays silent.
        fill(3);
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_pix = 8'(img[k / W][k % W]);
        end
        @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        check_idle_outputs("midreset");
        clear_capture();
        repeat (15) begin
            @(posedge clk); #1 in_valid = 1'b1; in_pix = 8'($urandom);
        end
        #1 in_valid = 1'b0;
        check("midreset_no_output", q_pix.size(), 0);
        check("midreset_busy", int'(busy), 0);
        fill(1); run_frame(0, 1'b0, 1'b0); check_frame(1'b0); check_probes();

        fill(0); run_frame(0, 1'b1, 1'b0); check_frame(1'b0);

        for (int f = 0; f < 3; f++) begin
            fill(3); run_frame(2, 1'b0, 1'b0); check_frame(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
